// File: rtl/tdm_pkg.sv
// Shared TDM definitions: parameter defaults, FSM encoding, slot width.
// Used by both the TDM mux and demux stages.
package tdm_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 8;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// TDM sample stream in, published frame and status out.
// master drives the stream, slave is the demux.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  localparam int SW = slot_w(NCH)
);

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_sync;
  logic [NCH*W-1:0] out_data;
  logic             out_valid;
  logic [SW-1:0]    out_slot;
  logic             locked;
  logic             sync_err;

  modport master (
    output in_data,
    output in_valid,
    output in_sync,
    input  out_data,
    input  out_valid,
    input  out_slot,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sync,
    output out_data,
    output out_valid,
    output out_slot,
    output locked,
    output sync_err
  );

endinterface

// File: rtl/tdm_slot_cnt.sv
// Modulo-NCH slot counter with enable, load-to-1 and wrap flag.
// NCH need not be a power of two; wrap is an explicit compare.
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  localparam int SW = slot_w(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load1_i,
  output logic [SW-1:0] slot_o,
  output logic          wrap_o
);

  localparam logic [SW-1:0] LAST = SW'(NCH - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  assign wrap_o = (slot_q == LAST);
  assign slot_o = slot_q;

  always_comb begin
    slot_d = slot_q;
    if (load1_i) begin
      slot_d = ONE;
    end else if (en_i) begin
      slot_d = wrap_o ? '0 : slot_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive stage: collects slot samples into a shadow buffer and
// publishes each completed frame atomically with a one-cycle strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  localparam int SW = slot_w(NCH)
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  logic [0:0] state_q;
  logic [0:0] state_d;

  logic [(NCH-1)*W-1:0] shad_q;
  logic [(NCH-1)*W-1:0] shad_d;

  logic [NCH*W-1:0] dout_q;
  logic [NCH*W-1:0] dout_d;

  logic ov_q;
  logic ov_d;
  logic err_q;
  logic err_d;

  logic [SW-1:0] slot;
  logic          wrap;
  logic          is_lock;
  logic          sync_in;
  logic          data_in;
  logic          accept;
  logic          publish;
  logic [SW-1:0] wr_idx;

  assign is_lock = (state_q == LOCK);
  assign sync_in = bus.in_valid & bus.in_sync;
  assign data_in = bus.in_valid & ~bus.in_sync & is_lock;
  assign accept  = sync_in | data_in;
  assign publish = data_in & wrap;
  assign wr_idx  = bus.in_sync ? '0 : slot;

  tdm_slot_cnt #(
    .NCH (NCH)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .en_i    (data_in),
    .load1_i (sync_in),
    .slot_o  (slot),
    .wrap_o  (wrap)
  );

  always_comb begin
    state_d = state_q;
    if (sync_in) begin
      state_d = LOCK;
    end
  end

  // The last slot is never stored; it goes straight into the publish.
  always_comb begin
    shad_d = shad_q;
    for (int k = 0; k < NCH - 1; k++) begin
      if (accept && wr_idx == SW'(k)) begin
        shad_d[k*W +: W] = bus.in_data;
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    ov_d   = publish;
    err_d  = sync_in & is_lock & (slot != '0);
    if (publish) begin
      dout_d = {bus.in_data, shad_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      shad_q  <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shad_q  <= shad_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_data  = dout_q;
  assign bus.out_valid = ov_q;
  assign bus.out_slot  = slot;
  assign bus.locked    = is_lock;
  assign bus.sync_err  = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed table, hand sequences and
// randomized traffic against a frame-level queue model.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int SW  = 2;

  logic clk;
  logic rst;

  tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int npulse = 0;
  int nerr   = 0;

  // Frame-level model: samples of the frame being collected.
  logic [W-1:0]     mq[$];
  bit               mlk;
  logic [NCH*W-1:0] mod;
  bit               mov;
  bit               merr;

  typedef struct {
    bit               r;
    bit               v;
    bit               s;
    logic [W-1:0]     d;
    bit               ev;
    logic [NCH*W-1:0] ed;
    bit               el;
    int               es;
    bit               ee;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  function automatic void model(bit r, bit v, bit s, logic [W-1:0] d);
    mov  = 0;
    merr = 0;
    if (r) begin
      mq.delete();
      mlk = 0;
      mod = '0;
    end else if (v) begin
      if (s) begin
        if (mlk && mq.size() != 0) merr = 1;
        mq.delete();
        mq.push_back(d);
        mlk = 1;
      end else if (mlk) begin
        mq.push_back(d);
        if (mq.size() == NCH) begin
          for (int k = 0; k < NCH; k++) mod[k*W +: W] = mq[k];
          mov = 1;
          mq.delete();
        end
      end
    end
  endfunction

  task automatic step(bit r, bit v, bit s, logic [W-1:0] d);
    rst          = r;
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    model(r, v, s, d);
    chk("out_data", 64'(bus.out_data), 64'(mod));
    chk("out_valid", 64'(bus.out_valid), 64'(mov));
    chk("locked", 64'(bus.locked), 64'(mlk));
    chk("sync_err", 64'(bus.sync_err), 64'(merr));
    chk("out_slot", 64'(bus.out_slot), 64'(mq.size()));
    if (bus.out_valid) npulse++;
    if (bus.sync_err) nerr++;
  endtask

  function automatic vec_t mk(bit v, bit s, logic [W-1:0] d, bit ev,
                              logic [NCH*W-1:0] ed, bit el, int es);
    vec_t t;
    t.r  = 0;
    t.v  = v;
    t.s  = s;
    t.d  = d;
    t.ev = ev;
    t.ed = ed;
    t.el = el;
    t.es = es;
    t.ee = 0;
    return t;
  endfunction

  initial begin
    logic [NCH*W-1:0] last;
    logic [W-1:0]     dv;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;

    tbl.push_back(mk(1, 0, 8'hAA, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hBB, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h11, 0, 32'h0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h22, 0, 32'h0, 1, 2));
    tbl.push_back(mk(1, 0, 8'h33, 0, 32'h0, 1, 3));
    tbl.push_back(mk(1, 0, 8'h44, 1, 32'h44332211, 1, 0));
    tbl.push_back(mk(0, 1, 8'h55, 0, 32'h44332211, 1, 0));
    last = 32'h44332211;
    for (int i = 0; i < 12; i++) begin
      dv = W'(8'h10 + i);
      if (i % 4 == 3) last = {dv, dv - 8'd1, dv - 8'd2, dv - 8'd3};
      tbl.push_back(mk(1, (i % 4 == 0), dv, (i % 4 == 3),
                       last, 1, (i + 1) % 4));
    end

    // Reset with random traffic
    step(1, 1'($urandom), 1'($urandom), 8'($urandom));
    step(1, 1'($urandom), 1'($urandom), 8'($urandom));
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    chk("rst_locked", 64'(bus.locked), 64'h0);
    chk("rst_out_slot", 64'(bus.out_slot), 64'h0);

    npulse = 0;
    nerr   = 0;
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 64'(bus.out_data), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_locked", i), 64'(bus.locked), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_slot", i), 64'(bus.out_slot), 64'(tbl[i].es));
      chk($sformatf("tbl%0d_err", i), 64'(bus.sync_err), 64'(tbl[i].ee));
    end
    chk("tbl_pulses", 64'(npulse), 64'd4);
    chk("tbl_sync_errs", 64'(nerr), 64'd0);

    // Gapped frame
    npulse = 0;
    for (int i = 0; i < NCH; i++) begin
      step(0, 1, (i == 0), W'(i + 1));
      for (int g = 0; g < 3; g++) step(0, 0, 1'($urandom), 8'($urandom));
    end
    chk("gap_data", 64'(bus.out_data), 64'h04030201);
    chk("gap_pulses", 64'(npulse), 64'd1);

    // Misaligned sync drops the A frame
    npulse = 0;
    nerr   = 0;
    step(0, 1, 1, 8'hA0);
    step(0, 1, 0, 8'hA1);
    step(0, 1, 1, 8'hB0);
    chk("mis_err_pulse", 64'(bus.sync_err), 64'd1);
    step(0, 1, 0, 8'hB1);
    chk("mis_err_clear", 64'(bus.sync_err), 64'd0);
    step(0, 1, 0, 8'hB2);
    step(0, 1, 0, 8'hB3);
    chk("mis_data", 64'(bus.out_data), 64'hB3B2B1B0);
    chk("mis_pulses", 64'(npulse), 64'd1);
    chk("mis_errs", 64'(nerr), 64'd1);

    // Reset mid-frame
    npulse = 0;
    step(0, 1, 1, 8'hC0);
    step(0, 1, 0, 8'hC1);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < NCH; i++) step(0, 1, 0, W'(8'hD0 + i));
    chk("rmf_pulses", 64'(npulse), 64'd0);
    chk("rmf_locked", 64'(bus.locked), 64'd0);
    for (int i = 0; i < NCH; i++) step(0, 1, (i == 0), W'(8'hE0 + i));
    chk("rmf_data", 64'(bus.out_data), 64'hE3E2E1E0);
    chk("rmf_pulses2", 64'(npulse), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 6) == 0),
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
